// File: rtl/alu_control_unit.sv
// alu_control_unit
//   ALU-control decoder for a single-cycle MIPS datapath. Maps the main
//   control unit's ALUOp class and the R-type function field to the 4-bit
//   ALU operation code. It also keeps a registered copy of the decode and a
//   saturating count of illegal R-type function codes, for pipelined reuse
//   and for debug.
//
// Ports
//   CLK           in   system clock, rising-edge registers
//   Reset         in   asynchronous active-low reset
//   En            in   update enable for all registered outputs
//   ALUOp[1:0]    in   operation class (00 ld/st/addi, 01 branch, 10 R-type, 11 ori-class)
//   FuncCode[5:0] in   R-type function field
//   ALUControl    out  combinational ALU operation code
//   Illegal       out  combinational flag: R-type with an unsupported FuncCode
//   ALUControl_r  out  registered ALUControl
//   Illegal_r     out  registered Illegal
//   IllegalCount  out  saturating count of illegal decodes captured with En=1
module alu_control_unit #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  output logic [3:0]       ALUControl,
  output logic             Illegal,
  output logic [3:0]       ALUControl_r,
  output logic             Illegal_r,
  output logic [CNT_W-1:0] IllegalCount
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       w_alu_ctrl;
  logic             w_illegal;
  logic [3:0]       r_alu_ctrl;
  logic             r_illegal;
  logic [CNT_W-1:0] r_ill_cnt;

  // Defaults are assigned first so that an X on ALUOp or FuncCode lands on
  // ADD instead of propagating through a case fall-through.
  always_comb begin
    w_alu_ctrl = OP_ADD;
    w_illegal  = 1'b0;
    case (ALUOp)
      2'b00: w_alu_ctrl = OP_ADD;
      2'b01: w_alu_ctrl = OP_SUB;
      2'b11: w_alu_ctrl = OP_OR;
      2'b10: begin
        case (FuncCode)
          6'b100000: w_alu_ctrl = OP_ADD;  // add
          6'b100001: w_alu_ctrl = OP_ADD;  // addu
          6'b100010: w_alu_ctrl = OP_SUB;  // sub
          6'b100011: w_alu_ctrl = OP_SUB;  // subu
          6'b100100: w_alu_ctrl = OP_AND;
          6'b100101: w_alu_ctrl = OP_OR;
          6'b100111: w_alu_ctrl = OP_NOR;
          6'b101010: w_alu_ctrl = OP_SLT;
          default: begin
            w_alu_ctrl = OP_ADD;
            w_illegal  = 1'b1;
          end
        endcase
      end
      default: begin
        w_alu_ctrl = OP_ADD;
        w_illegal  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_alu_ctrl <= OP_ADD;
      r_illegal  <= 1'b0;
      r_ill_cnt  <= '0;
    end else if (En) begin
      r_alu_ctrl <= w_alu_ctrl;
      r_illegal  <= w_illegal;
      // Saturate rather than wrap, so a long run of bad opcodes stays visible.
      if (w_illegal && (r_ill_cnt != CNT_MAX))
        r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  assign ALUControl   = w_alu_ctrl;
  assign Illegal      = w_illegal;
  assign ALUControl_r = r_alu_ctrl;
  assign Illegal_r    = r_illegal;
  assign IllegalCount = r_ill_cnt;

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             Reset = 1'b0;
  logic             En = 1'b0;
  logic [1:0]       ALUOp = 2'b00;
  logic [5:0]       FuncCode = 6'b000000;
  logic [3:0]       ALUControl;
  logic             Illegal;
  logic [3:0]       ALUControl_r;
  logic             Illegal_r;
  logic [CNT_W-1:0] IllegalCount;

  alu_control_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .En(En), .ALUOp(ALUOp), .FuncCode(FuncCode),
    .ALUControl(ALUControl), .Illegal(Illegal), .ALUControl_r(ALUControl_r),
    .Illegal_r(Illegal_r), .IllegalCount(IllegalCount)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Supported R-type functions and their ALU codes.
  logic [5:0] tbl_f [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [3:0] tbl_c [8] = '{4'd2,  4'd2,  4'd6,  4'd6,  4'd0,  4'd1,  4'd12, 4'd7};

  // Reference state of the registered outputs.
  int m_ctrl = 2;
  int m_ill  = 0;
  int m_cnt  = 0;

  typedef struct { int ctrl; int ill; int cnt; } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output int c, output int il);
    c = 2;
    il = 0;
    if (op == 2'b01) c = 6;
    else if (op == 2'b11) c = 1;
    else if (op == 2'b10) begin
      il = 1;
      for (int i = 0; i < 8; i++)
        if (f == tbl_f[i]) begin
          c = int'(tbl_c[i]);
          il = 0;
        end
    end
  endfunction

  // Asynchronous reset clears the reference state immediately.
  always @(negedge Reset) begin
    m_ctrl = 2;
    m_ill  = 0;
    m_cnt  = 0;
  end

  // Every rising edge yields one expected registered state.
  always @(posedge CLK) begin
    int c, il;
    exp_t e;
    if (Reset && En) begin
      ref_decode(ALUOp, FuncCode, c, il);
      m_ctrl = c;
      m_ill  = il;
      if (il == 1 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    e.ctrl = m_ctrl;
    e.ill  = m_ill;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  end

  // Monitor: compares registered outputs once they have settled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ALUControl_r", int'(ALUControl_r), e.ctrl);
        check("Illegal_r",    int'(Illegal_r),    e.ill);
        check("IllegalCount", int'(IllegalCount), e.cnt);
      end
    end
  end

  // Drive one cycle of inputs well away from the edges and check the
  // combinational decode.
  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic en);
    int c, il;
    @(negedge CLK);
    #2;
    ALUOp = op;
    FuncCode = f;
    En = en;
    #1;
    ref_decode(op, f, c, il);
    check("ALUControl", int'(ALUControl), c);
    check("Illegal",    int'(Illegal),    il);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    check("rst ALUControl_r", int'(ALUControl_r), 2);
    check("rst IllegalCount", int'(IllegalCount), 0);
    @(negedge CLK);
    #2;
    Reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [5:0] sweep_f [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

  initial begin
    // 1: decode live during reset, registers held at reset values.
    drive(2'b00, 6'b101010, 1'b1);
    drive(2'b01, 6'b101010, 1'b1);
    check("reset ALUControl_r", int'(ALUControl_r), 2);
    check("reset IllegalCount", int'(IllegalCount), 0);

    // X on ALUOp must fall to ADD.
    @(negedge CLK);
    #2;
    En = 1'b0;
    ALUOp = 2'bxx;
    #1;
    check("X ALUControl", (ALUControl === 4'b0010) ? 1 : 0, 1);

    @(negedge CLK);
    #2;
    Reset = 1'b1;

    // 2: R-type sweep.
    for (int i = 0; i < 6; i++) drive(2'b10, sweep_f[i], 1'b1);
    drive(2'b00, 6'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] f;
      if ($urandom_range(1, 0) == 1) f = tbl_f[$urandom_range(7, 0)];
      else f = 6'($urandom);
      drive(2'($urandom), f, ($urandom_range(3, 0) != 0));
    end

    // 3: three illegal captures from a fresh count.
    pulse_reset();
    for (int i = 0; i < 3; i++) drive(2'b10, 6'b000000, 1'b1);
    drive(2'b00, 6'b000000, 1'b0);
    check("illegal x3 count", int'(IllegalCount), 3);
    check("illegal x3 Illegal_r", int'(Illegal_r), 1);

    // 5: En=0 holds registers while inputs change.
    for (int i = 0; i < 20; i++) drive(2'($urandom), 6'($urandom), 1'b0);
    check("hold count", int'(IllegalCount), 3);

    // 4: saturation.
    for (int i = 0; i < 300; i++) drive(2'b10, 6'b111111, 1'b1);
    drive(2'b00, 6'b000000, 1'b0);
    check("saturated count", int'(IllegalCount), CNT_MAX);

    // 6: reset between edges with a count of 5.
    pulse_reset();
    for (int i = 0; i < 5; i++) drive(2'b10, 6'b111110, 1'b1);
    drive(2'b10, 6'b100101, 1'b0);
    check("pre-reset count", int'(IllegalCount), 5);
    pulse_reset();
    drive(2'b11, 6'h00, 1'b1);
    drive(2'b10, 6'h2A, 1'b1);

    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- ALU-control decoder for the single-cycle MIPS datapath. Sits between the main control unit (ALUOp) and the ALU, which consumes the 4-bit operation code.
- Maps the 2-bit ALUOp and the R-type function field (instruction bits [5:0]) to the ALU operation code.
- Provides a combinational path for the single-cycle ALU, plus a registered copy and illegal-function bookkeeping for pipelined reuse and debug.

Parameters:
- CNT_W, 8, width of the saturating illegal-function counter.

Ports:
- CLK  input  1  system clock; all registers update on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- En  input  1  register-update enable for all registered outputs.
- ALUOp  input  2  operation class from the main control unit.
- FuncCode  input  6  R-type function field.
- ALUControl  output  4  combinational ALU operation code.
- Illegal  output  1  combinational flag: ALUOp=10 with an unsupported FuncCode.
- ALUControl_r  output  4  registered ALUControl.
- Illegal_r  output  1  registered Illegal.
- IllegalCount  output  CNT_W  saturating count of illegal decodes.

Behaviour:
- ALU operation codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- ALUOp=00 (load/store/addi): ALUControl=0010, FuncCode ignored, Illegal=0.
- ALUOp=01 (beq/bne): ALUControl=0110, FuncCode ignored, Illegal=0.
- ALUOp=11 (ori-class immediate logic): ALUControl=0001, FuncCode ignored, Illegal=0.
- ALUOp=10 (R-type), decode on FuncCode:
  - 100000 add -> 0010
  - 100001 addu -> 0010
  - 100010 sub -> 0110
  - 100011 subu -> 0110
  - 100100 and -> 0000
  - 100101 or -> 0001
  - 100111 nor -> 1100
  - 101010 slt -> 0111
  - any other FuncCode -> ALUControl=0010, Illegal=1
- Combinational outputs:
  - Pure function of the current ALUOp and FuncCode; zero latency.
  - No latches: every input combination assigns both outputs.
  - Any X on an input produces the default (0010, Illegal per the rules above); no X propagates from a case fall-through.
- Registered outputs:
  - While Reset=0, asynchronously: ALUControl_r=0010, Illegal_r=0, IllegalCount=0. Combinational outputs remain live during reset.
  - On a rising CLK edge with Reset=1 and En=1: ALUControl_r<=ALUControl and Illegal_r<=Illegal (one-cycle latency). If Illegal=1, IllegalCount increments by 1, saturating at 2^CNT_W-1 with no wrap.
  - With En=0: all registers hold their values.
- Reset deassertion is synchronized by the system; the first capture occurs on the first rising edge with Reset=1.
- Reset asserted mid-operation clears the registers immediately, independent of CLK.
- Reset and En asserted together: reset wins.

Test Plan:
1. Reset=0, then ALUOp=00 and ALUOp=01 with FuncCode=101010 -> ALUControl=0010 then 0110, Illegal=0 in both cases; during reset ALUControl_r=0010, IllegalCount=0.
2. Reset=1, En=1, ALUOp=10, sweep FuncCode over 100000/100010/100100/100101/101010/100111 -> ALUControl=0010/0110/0000/0001/0111/1100; ALUControl_r reproduces the same sequence one cycle later.
3. ALUOp=10, FuncCode=000000 for 3 edges with En=1 -> Illegal=1, ALUControl=0010, Illegal_r=1 after the first edge, IllegalCount=3.
4. Drive FuncCode=111111 with ALUOp=10 for 300 cycles (CNT_W=8) -> IllegalCount reaches 255 and stays at 255.
5. En=0 with changing ALUOp/FuncCode -> combinational outputs track the inputs; ALUControl_r, Illegal_r and IllegalCount hold.
6. Assert Reset=0 between clock edges with IllegalCount=5 -> IllegalCount=0 and ALUControl_r=0010 immediately, with no clock edge.
